// File: rtl/sonar_pkg.sv
// Shared types and helpers for the sonar ping sequencer and its angle stepper.
package sonar_pkg;

    // Scan mode encoding. It matches the 2-bit mode_in port value for value.
    typedef enum logic [1:0] {
        SCAN_BOUNCE = 2'd0,
        SCAN_WRAP   = 2'd1,
        SCAN_FIXED  = 2'd2,
        SCAN_STOP   = 2'd3
    } scan_mode_t;

    // Ping sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_BURST  = 2'd1,
        SEQ_LISTEN = 2'd2
    } seq_state_t;

    // Elaboration-time clamp, used to derive reset values from the sweep limits
    function automatic int clamp_int(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/angle_stepper.sv
// Beam angle stepper: holds the steering angle, bounce direction and dwell count.
// It advances only on step_en, which the sequencer asserts at each ping boundary.
module angle_stepper
    import sonar_pkg::*;
#(
    parameter int ANGLE_WIDTH = 8,
    parameter int ANGLE_MIN   = -30,
    parameter int ANGLE_MAX   = 30,
    parameter int ANGLE_STEP  = 1,
    parameter int DWELL_PINGS = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_step_en,
    input  scan_mode_t                    i_mode,
    input  logic signed [ANGLE_WIDTH-1:0] i_fixed_angle,
    output logic signed [ANGLE_WIDTH-1:0] o_angle
);

    // One guard bit so that angle +/- step can never overflow before the clamp
    localparam int XW  = ANGLE_WIDTH + 1;
    localparam int DCW = $clog2(DWELL_PINGS + 1);

    localparam logic signed [XW-1:0] C_MIN  = XW'(ANGLE_MIN);
    localparam logic signed [XW-1:0] C_MAX  = XW'(ANGLE_MAX);
    localparam logic signed [XW-1:0] C_STEP = XW'(ANGLE_STEP);
    localparam logic signed [XW-1:0] C_RST  = XW'(clamp_int(0, ANGLE_MIN, ANGLE_MAX));
    localparam logic [DCW-1:0]       C_DWELL = DCW'(DWELL_PINGS);

    logic signed [ANGLE_WIDTH-1:0] r_angle;
    logic                          r_dir_up;
    logic                          r_last_bounce;
    logic [DCW-1:0]                r_dwell;

    logic signed [XW-1:0] w_cur;
    logic signed [XW-1:0] w_up;
    logic signed [XW-1:0] w_dn;
    logic signed [XW-1:0] w_fix;
    logic signed [XW-1:0] w_angle_next;
    logic                 w_dir_eff;
    logic                 w_dir_next;
    logic [DCW-1:0]       w_dwell_inc;
    logic [DCW-1:0]       w_dwell_next;

    assign w_cur       = {r_angle[ANGLE_WIDTH-1], r_angle};
    assign w_up        = w_cur + C_STEP;
    assign w_dn        = w_cur - C_STEP;
    assign w_fix       = {i_fixed_angle[ANGLE_WIDTH-1], i_fixed_angle};
    assign w_dwell_inc = r_dwell + DCW'(1);
    // Entering bounce from any other mode restarts the sweep upwards
    assign w_dir_eff   = (r_last_bounce) ? r_dir_up : 1'b1;

    // Next angle, direction and dwell count for the upcoming ping boundary
    always_comb begin
        w_angle_next = w_cur;
        w_dir_next   = r_dir_up;
        w_dwell_next = r_dwell;
        case (i_mode)
            SCAN_FIXED: begin
                w_dwell_next = '0;
                if (w_fix < C_MIN) begin
                    w_angle_next = C_MIN;
                end else if (w_fix > C_MAX) begin
                    w_angle_next = C_MAX;
                end else begin
                    w_angle_next = w_fix;
                end
            end
            SCAN_BOUNCE: begin
                w_dir_next = w_dir_eff;
                if (w_dwell_inc >= C_DWELL) begin
                    w_dwell_next = '0;
                    // Reaching or passing a limit parks on it and turns around
                    if (w_dir_eff) begin
                        if (w_up >= C_MAX) begin
                            w_angle_next = C_MAX;
                            w_dir_next   = 1'b0;
                        end else begin
                            w_angle_next = w_up;
                        end
                    end else begin
                        if (w_dn <= C_MIN) begin
                            w_angle_next = C_MIN;
                            w_dir_next   = 1'b1;
                        end else begin
                            w_angle_next = w_dn;
                        end
                    end
                end else begin
                    w_dwell_next = w_dwell_inc;
                end
            end
            SCAN_WRAP: begin
                if (w_dwell_inc >= C_DWELL) begin
                    w_dwell_next = '0;
                    if (w_up > C_MAX) begin
                        w_angle_next = C_MIN;
                    end else begin
                        w_angle_next = w_up;
                    end
                end else begin
                    w_dwell_next = w_dwell_inc;
                end
            end
            default: begin
                // Stop mode holds the angle where it is
            end
        endcase
    end

    // Commit the stepper state at ping boundaries only
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_angle       <= C_RST[ANGLE_WIDTH-1:0];
            r_dir_up      <= 1'b1;
            r_last_bounce <= 1'b0;
            r_dwell       <= '0;
        end else if (i_step_en) begin
            r_angle       <= w_angle_next[ANGLE_WIDTH-1:0];
            r_dir_up      <= w_dir_next;
            r_last_bounce <= (i_mode == SCAN_BOUNCE);
            r_dwell       <= w_dwell_next;
        end
    end

    assign o_angle = r_angle;

endmodule

// File: rtl/scan_ping_sequencer.sv
// Sonar ping scheduler: burst/listen timing, ADC trigger pacing, first-echo
// capture after blanking, and one result record per completed ping.
module scan_ping_sequencer
    import sonar_pkg::*;
#(
    parameter int PERIOD_CYCLES = 16777216,
    parameter int BURST_CYCLES  = 524288,
    parameter int BLANK_CYCLES  = 20000,
    parameter int SAMPLE_DIV    = 100,
    parameter int ANGLE_WIDTH   = 8,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 1,
    parameter int DWELL_PINGS   = 8,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [1:0]                           mode_in,
    input  logic signed [ANGLE_WIDTH-1:0]        fixed_angle_in,
    input  logic [DATA_WIDTH-1:0]                threshold_in,
    input  logic [DATA_WIDTH-1:0]                sample_in,
    input  logic                                 sample_valid_in,
    output logic                                 burst_start_out,
    output logic                                 burst_active_out,
    output logic signed [ANGLE_WIDTH-1:0]        beam_angle_out,
    output logic                                 sample_trig_out,
    output logic [$clog2(PERIOD_CYCLES)-1:0]     time_out,
    output logic                                 result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0]        result_angle_out,
    output logic [$clog2(PERIOD_CYCLES)-1:0]     result_time_out,
    output logic                                 result_hit_out
);

    localparam int TW  = $clog2(PERIOD_CYCLES);
    localparam int DVW = $clog2(SAMPLE_DIV + 1);

    localparam logic [TW-1:0]  C_T_LAST     = TW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0]  C_BURST_LAST = TW'(BURST_CYCLES - 1);
    localparam logic [31:0]    C_QUAL_START = 32'(BURST_CYCLES + BLANK_CYCLES);
    localparam logic [DVW-1:0] C_DIV_LAST   = DVW'(SAMPLE_DIV - 1);

    seq_state_t                    r_state;
    logic [TW-1:0]                 r_t;
    logic [DVW-1:0]                r_div;
    logic                          r_burst_start;
    logic                          r_burst_active;
    logic                          r_trig;
    logic                          r_hit;
    logic [TW-1:0]                 r_echo_t;
    logic                          r_result_valid;
    logic signed [ANGLE_WIDTH-1:0] r_result_angle;
    logic [TW-1:0]                 r_result_time;
    logic                          r_result_hit;

    scan_mode_t                    w_mode;
    logic                          w_boundary;
    logic                          w_start;
    logic                          w_qual;
    logic signed [ANGLE_WIDTH-1:0] w_angle;

    assign w_mode     = scan_mode_t'(mode_in);
    // Last cycle of a ping: results are captured and the angle may step here
    assign w_boundary = (r_state == SEQ_LISTEN) && (r_t == C_T_LAST);
    // A new ping starts from IDLE or straight after a boundary unless stopped
    assign w_start    = (w_mode != SCAN_STOP) &&
                        ((r_state == SEQ_IDLE) || w_boundary);
    // Echo candidate: valid sample, past blanking, strictly above threshold
    assign w_qual     = (r_state == SEQ_LISTEN) && sample_valid_in &&
                        (32'(r_t) >= C_QUAL_START) && (sample_in > threshold_in);

    angle_stepper #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .ANGLE_MIN   (ANGLE_MIN),
        .ANGLE_MAX   (ANGLE_MAX),
        .ANGLE_STEP  (ANGLE_STEP),
        .DWELL_PINGS (DWELL_PINGS)
    ) u_angle_stepper (
        .i_clk         (clk_in),
        .i_rst_n       (rst_in),
        .i_step_en     (w_boundary),
        .i_mode        (w_mode),
        .i_fixed_angle (fixed_angle_in),
        .o_angle       (w_angle)
    );

    // Ping FSM: timing counter, trigger divider, echo latch and result record
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state        <= SEQ_IDLE;
            r_t            <= '0;
            r_div          <= '0;
            r_burst_start  <= 1'b0;
            r_burst_active <= 1'b0;
            r_trig         <= 1'b0;
            r_hit          <= 1'b0;
            r_echo_t       <= '0;
            r_result_valid <= 1'b0;
            r_result_angle <= '0;
            r_result_time  <= '0;
            r_result_hit   <= 1'b0;
        end else begin
            r_burst_start  <= 1'b0;
            r_trig         <= 1'b0;
            r_result_valid <= 1'b0;

            // Only the first qualified echo of a ping is kept
            if (w_qual && !r_hit) begin
                r_hit    <= 1'b1;
                r_echo_t <= r_t;
            end

            // An echo on the very last cycle still belongs to this ping
            if (w_boundary) begin
                r_result_valid <= 1'b1;
                r_result_angle <= w_angle;
                r_result_hit   <= r_hit | w_qual;
                if (r_hit) begin
                    r_result_time <= r_echo_t;
                end else if (w_qual) begin
                    r_result_time <= r_t;
                end else begin
                    r_result_time <= '0;
                end
            end

            if (w_start) begin
                r_state        <= SEQ_BURST;
                r_t            <= '0;
                r_div          <= '0;
                r_burst_start  <= 1'b1;
                r_burst_active <= 1'b1;
                r_hit          <= 1'b0;
                r_echo_t       <= '0;
            end else if (w_boundary) begin
                r_state  <= SEQ_IDLE;
                r_t      <= '0;
                r_hit    <= 1'b0;
                r_echo_t <= '0;
            end else begin
                case (r_state)
                    SEQ_BURST: begin
                        r_t <= r_t + TW'(1);
                        if (r_t == C_BURST_LAST) begin
                            r_state        <= SEQ_LISTEN;
                            r_burst_active <= 1'b0;
                            r_trig         <= 1'b1;
                            r_div          <= '0;
                        end
                    end
                    SEQ_LISTEN: begin
                        r_t <= r_t + TW'(1);
                        if (r_div == C_DIV_LAST) begin
                            r_div  <= '0;
                            r_trig <= 1'b1;
                        end else begin
                            r_div <= r_div + DVW'(1);
                        end
                    end
                    default: begin
                        // IDLE with stop requested: hold
                    end
                endcase
            end
        end
    end

    assign burst_start_out  = r_burst_start;
    assign burst_active_out = r_burst_active;
    assign beam_angle_out   = w_angle;
    assign sample_trig_out  = r_trig;
    assign time_out         = r_t;
    assign result_valid_out = r_result_valid;
    assign result_angle_out = r_result_angle;
    assign result_time_out  = r_result_time;
    assign result_hit_out   = r_result_hit;

endmodule
